// File: rtl/sc_regbank.sv
// Fourteen-entry register bank with constant r0/r1, two registered read ports,
// write-first forwarding and a sticky flag for illegal multi-strobe loads.
module sc_regbank #(
    parameter int DATAWIDTH_BUS          = 32,
    parameter int DATAWIDTH_REGFIXED_SEL = 4,
    parameter int DATAWIDTH_LOAD         = 14,
    parameter int CONST_R1               = 1
) (
    input  logic                              CLOCK_50,
    input  logic                              RESET_InHigh,
    input  logic [DATAWIDTH_LOAD-1:0]         SC_REGBANK_load_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]          SC_REGBANK_data_InBUS,
    input  logic [DATAWIDTH_REGFIXED_SEL-1:0] SC_REGBANK_selA_InBUS,
    input  logic [DATAWIDTH_REGFIXED_SEL-1:0] SC_REGBANK_selB_InBUS,
    input  logic                              SC_REGBANK_clrerr_In,
    output logic [DATAWIDTH_BUS-1:0]          SC_REGBANK_busA_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]          SC_REGBANK_busB_OutBUS,
    output logic                              SC_REGBANK_loaderr_Out
);

    // r_regs[k] holds architectural register r(k+2)
    logic [DATAWIDTH_BUS-1:0]  r_regs [DATAWIDTH_LOAD];
    logic [DATAWIDTH_BUS-1:0]  r_busA;
    logic [DATAWIDTH_BUS-1:0]  r_busB;
    logic                      r_err;

    logic [DATAWIDTH_LOAD-1:0] w_req;
    logic                      w_any;
    logic                      w_one;
    logic                      w_multi;
    logic [DATAWIDTH_LOAD-1:0] w_wr;
    logic [DATAWIDTH_BUS-1:0]  w_const;
    logic [DATAWIDTH_BUS-1:0]  w_rdA;
    logic [DATAWIDTH_BUS-1:0]  w_rdB;

    assign w_const = DATAWIDTH_BUS'(CONST_R1);

    // Strobe qualification: a write happens only when exactly one strobe is low
    always_comb begin
        w_req   = ~SC_REGBANK_load_InBUS;
        w_any   = |w_req;
        w_one   = w_any && ((w_req & (w_req - 1'b1)) == '0);
        w_multi = w_any && !w_one;
        w_wr    = w_one ? w_req : '0;
    end

    // Read muxes with write-first forwarding of an accepted write
    always_comb begin
        w_rdA = '0;
        w_rdB = '0;
        for (int k = 0; k < DATAWIDTH_LOAD; k++) begin
            if (32'(SC_REGBANK_selA_InBUS) == 32'(k + 2)) begin
                w_rdA = w_wr[k] ? SC_REGBANK_data_InBUS : r_regs[k];
            end
            if (32'(SC_REGBANK_selB_InBUS) == 32'(k + 2)) begin
                w_rdB = w_wr[k] ? SC_REGBANK_data_InBUS : r_regs[k];
            end
        end
        if (32'(SC_REGBANK_selA_InBUS) == 32'd1) begin
            w_rdA = w_const;
        end
        if (32'(SC_REGBANK_selB_InBUS) == 32'd1) begin
            w_rdB = w_const;
        end
    end

    // Storage, read registers and sticky error flag; reset overrides everything
    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            for (int k = 0; k < DATAWIDTH_LOAD; k++) begin
                r_regs[k] <= '0;
            end
            r_busA <= '0;
            r_busB <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int k = 0; k < DATAWIDTH_LOAD; k++) begin
                if (w_wr[k]) begin
                    r_regs[k] <= SC_REGBANK_data_InBUS;
                end
            end
            r_busA <= w_rdA;
            r_busB <= w_rdB;
            if (w_multi) begin
                r_err <= 1'b1;
            end else if (SC_REGBANK_clrerr_In) begin
                r_err <= 1'b0;
            end
        end
    end

    assign SC_REGBANK_busA_OutBUS = r_busA;
    assign SC_REGBANK_busB_OutBUS = r_busB;
    assign SC_REGBANK_loaderr_Out = r_err;

endmodule

// File: tb/tb_sc_regbank.sv
// Testbench for sc_regbank: directed vector table followed by
// randomized traffic compared against an array-based reference model.
module tb_sc_regbank;

    logic        clk;
    logic        rst;
    logic [13:0] ld;
    logic [31:0] d;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic        clr;
    logic [31:0] busA;
    logic [31:0] busB;
    logic        err;

    int n_chk;
    int n_fail;

    sc_regbank dut (
        .CLOCK_50               (clk),
        .RESET_InHigh           (rst),
        .SC_REGBANK_load_InBUS  (ld),
        .SC_REGBANK_data_InBUS  (d),
        .SC_REGBANK_selA_InBUS  (sa),
        .SC_REGBANK_selB_InBUS  (sb),
        .SC_REGBANK_clrerr_In   (clr),
        .SC_REGBANK_busA_OutBUS (busA),
        .SC_REGBANK_busB_OutBUS (busB),
        .SC_REGBANK_loaderr_Out (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [13:0] ld;
        logic [31:0] d;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        clr;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ee;
    } vec_t;

    vec_t tbl [17];

    // reference model state
    logic [31:0] mem [16];
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [13:0] l,
                         input logic [31:0] dd, input logic [3:0] a,
                         input logic [3:0] b, input logic c);
        rst = r;
        ld  = l;
        d   = dd;
        sa  = a;
        sb  = b;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    // One clock of the model, derived directly from the bank's rules
    task automatic model_step(input logic r, input logic [13:0] l,
                              input logic [31:0] dd, input logic [3:0] a,
                              input logic [3:0] b, input logic c,
                              output logic [31:0] ea, output logic [31:0] eb);
        int nlow;
        nlow = $countones(~l);
        if (r) begin
            for (int i = 2; i < 16; i++) mem[i] = 32'h0;
            m_err = 1'b0;
            ea = 32'h0;
            eb = 32'h0;
        end else begin
            if (nlow == 1) begin
                for (int k = 0; k < 14; k++)
                    if (!l[k]) mem[k + 2] = dd;
            end
            if (nlow >= 2) m_err = 1'b1;
            else if (c) m_err = 1'b0;
            ea = mem[a];
            eb = mem[b];
        end
    endtask

    function automatic vec_t mk(logic r, logic [13:0] l, logic [31:0] dd,
                                logic [3:0] a, logic [3:0] b, logic c,
                                logic [31:0] ea, logic [31:0] eb, logic ee);
        vec_t v;
        v.rst = r; v.ld = l; v.d = dd; v.a = a; v.b = b; v.clr = c;
        v.ea = ea; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    localparam logic [13:0] NONE = 14'h3fff;

    initial begin
        logic [31:0] ea;
        logic [31:0] eb;
        logic [13:0] l;
        logic        r;
        logic        c;
        logic [31:0] dd;
        logic [3:0]  a;
        logic [3:0]  b;
        int          i0;
        int          i1;
        int          mode;

        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1; ld = NONE; d = '0; sa = '0; sb = '0; clr = 1'b0;

        tbl[0]  = mk(1, NONE, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        tbl[1]  = mk(0, NONE, 0, 0, 1, 0, 32'h0, 32'h1, 0);
        tbl[2]  = mk(0, 14'b11111111111110, 32'hA5A5A5A5, 2, 0, 0,
                     32'hA5A5A5A5, 32'h0, 0);
        tbl[3]  = mk(0, NONE, 0, 2, 2, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0);
        tbl[4]  = mk(0, 14'b01111111111111, 32'h12345678, 0, 1, 0,
                     32'h0, 32'h1, 0);
        tbl[5]  = mk(0, NONE, 0, 15, 15, 0, 32'h12345678, 32'h12345678, 0);
        tbl[6]  = mk(0, 14'b11111111111101, 32'h11, 3, 2, 0,
                     32'h11, 32'hA5A5A5A5, 0);
        tbl[7]  = mk(0, 14'b11111111111011, 32'h22, 4, 3, 0,
                     32'h22, 32'h11, 0);
        tbl[8]  = mk(0, 14'b11111111111001, 32'hFF, 3, 4, 0,
                     32'h11, 32'h22, 1);
        tbl[9]  = mk(0, NONE, 0, 3, 4, 0, 32'h11, 32'h22, 1);
        tbl[10] = mk(0, NONE, 0, 0, 1, 1, 32'h0, 32'h1, 0);
        tbl[11] = mk(0, 14'b11111111111001, 32'hFF, 3, 4, 1,
                     32'h11, 32'h22, 1);
        tbl[12] = mk(0, NONE, 0, 1, 0, 1, 32'h1, 32'h0, 0);
        tbl[13] = mk(0, 14'b11111101111111, 32'h55, 9, 1, 0,
                     32'h55, 32'h1, 0);
        tbl[14] = mk(1, 14'b11111101111111, 32'h77, 9, 15, 0,
                     32'h0, 32'h0, 0);
        tbl[15] = mk(0, NONE, 0, 9, 15, 0, 32'h0, 32'h0, 0);
        tbl[16] = mk(0, 14'b11111101111111, 32'h77, 9, 0, 0,
                     32'h77, 32'h0, 0);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].ld, tbl[i].d, tbl[i].a, tbl[i].b,
                  tbl[i].clr);
            chk($sformatf("vec%0d busA", i), busA, tbl[i].ea);
            chk($sformatf("vec%0d busB", i), busB, tbl[i].eb);
            chk($sformatf("vec%0d loaderr", i), {31'b0, err}, {31'b0, tbl[i].ee});
        end

        // hand sequence: reset mid-stream, multi-load with clr held afterwards
        drive(0, 14'b11011111111111, 32'hCAFE0001, 13, 0, 0);
        chk("seq fwd r13", busA, 32'hCAFE0001);
        drive(0, 14'b00111111111111, 32'hDEAD, 14, 15, 1);
        chk("seq multi err", {31'b0, err}, 32'h1);
        chk("seq multi r14", busA, 32'h0);
        drive(1, 14'b11011111111111, 32'h1, 13, 1, 1);
        chk("seq reset busA", busA, 32'h0);
        chk("seq reset err", {31'b0, err}, 32'h0);
        drive(0, NONE, 0, 13, 1, 0);
        chk("seq r13 cleared", busA, 32'h0);
        chk("seq r1 const", busB, 32'h1);

        // randomized traffic against the model, starting from reset
        mem[0] = 32'h0;
        mem[1] = 32'h1;
        model_step(1, NONE, 0, 0, 0, 0, ea, eb);
        drive(1, NONE, 0, 0, 0, 0);
        for (int n = 0; n < 2000; n++) begin
            r    = ($urandom_range(0, 40) == 0);
            c    = ($urandom_range(0, 7) == 0);
            dd   = $urandom;
            a    = 4'($urandom_range(0, 15));
            b    = 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 9);
            i0   = $urandom_range(0, 13);
            i1   = (i0 + $urandom_range(1, 13)) % 14;
            if (mode < 4) l = NONE;
            else if (mode < 9) l = ~(14'b1 << i0);
            else l = ~((14'b1 << i0) | (14'b1 << i1)) & 14'($urandom);
            model_step(r, l, dd, a, b, c, ea, eb);
            drive(r, l, dd, a, b, c);
            chk("rnd busA", busA, ea);
            chk("rnd busB", busB, eb);
            chk("rnd loaderr", {31'b0, err}, {31'b0, m_err});
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
